multiplication: RTL

MULTIPLICATION -- requirements
Module: multiplication

---
 rtl/multiplication_if.sv | 30 +++
 rtl/multiplication.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multiplication_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplication_if
// Description : Operand, result and status bundle for the shift-add
//               multiplier. The master drives start and the operands. The
//               slave returns the result and the busy/done status.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplication_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     r;
    logic [2*WIDTH-1:0]   a;
    logic                 busy;
    logic                 done;

    modport master (
        output start, q, b, r,
        input  a, busy, done
    );

    modport slave (
        input  start, q, b, r,
        output a, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/multiplication.sv
`default_nettype none
// ============================================================================
// Module      : multiplication
// Description : Sequential unsigned multiply-add, a = q*b + r. It processes
//               one multiplier bit per clock, least significant bit first.
//               This rebuilds the dividend from the quotient, divisor and
//               remainder of a completed division.
//               Optional macro MULTIPLICATION_EARLY_EXIT_EN ends the run on
//               the first edge after which no set multiplier bits remain.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplication #(
    parameter int WIDTH = 32
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    multiplication_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;   // latched q
    logic [WIDTH-1:0]     mcand_q,  mcand_d;    // latched b
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   a_q,      a_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last_step;
`ifdef MULTIPLICATION_EARLY_EXIT_EN
    logic [WIDTH-1:0]     remaining;
`endif

    // Partial product for the current bit, and the accumulator after adding it.
    always_comb begin
        partial = '0;
        if (mplier_q[cnt_q]) begin
            partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        end
        acc_sum = acc_q + partial;
    end

    // Decide whether the bit processed on this edge is the final one.
    always_comb begin
`ifdef MULTIPLICATION_EARLY_EXIT_EN
        // Bits above the current index are all that is left to process.
        remaining = mplier_q >> cnt_q;
        last_step = (cnt_q == LAST_IDX) || ((remaining >> 1) == '0);
`else
        last_step = (cnt_q == LAST_IDX);
`endif
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mplier_d = bus.q;
                    mcand_d  = bus.b;
                    acc_d    = {{WIDTH{1'b0}}, bus.r};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Inputs are not looked at here, so start and operand
                // changes during a run have no effect.
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    a_d     = acc_sum;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers. Reset takes effect at once and abandons any run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire
